// File: rtl/wb_retire_buffer.sv
// Write-back retire trace buffer: a first-word-fall-through FIFO of retired
// instruction records {pc, instruction, write_data, rd_addr, cycle stamp}.
// Commits arriving while full are dropped and tallied in a sticky overflow
// flag and a saturating drop counter.
module wb_retire_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_RegWrite,
  input  logic [31:0]                wb_pc,
  input  logic [31:0]                wb_instruction,
  input  logic [31:0]                wb_write_data,
  input  logic [4:0]                 wb_rd_addr,
  input  logic                       trace_ready,
  output logic                       trace_valid,
  output logic [31:0]                trace_pc,
  output logic [31:0]                trace_instruction,
  output logic [31:0]                trace_data,
  output logic [4:0]                 trace_rd,
  output logic [31:0]                trace_cycle,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Pointer wrap relies on natural AW-bit overflow, so DEPTH must be 2^n.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_retire_buffer: DEPTH must be a power of two and at least 2");
  end

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_data  [DEPTH];
  logic [4:0]    mem_rd    [DEPTH];
  logic [31:0]   mem_cycle [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cycle_q;
  logic          overflow_q;
  logic [15:0]   drop_count_q;

  logic          full, empty;
  logic          pop, push, drop;

  // Handshake decode: a pop frees a slot in the same edge, so a full buffer
  // can still accept a commit when the consumer is draining.
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    pop   = trace_ready && !empty;
    push  = wb_RegWrite && (!full || pop);
    drop  = wb_RegWrite && full && !pop;
  end

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, occupancy, cycle counter and drop accounting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cycle_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  // Record storage; contents are only meaningful behind valid pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]    <= wb_pc;
      mem_instr[wr_ptr_q] <= wb_instruction;
      mem_data[wr_ptr_q]  <= wb_write_data;
      mem_rd[wr_ptr_q]    <= wb_rd_addr;
      mem_cycle[wr_ptr_q] <= cycle_q;
    end
  end

  // Head entry falls through combinationally.
  always_comb begin
    trace_valid       = !empty;
    trace_pc          = mem_pc[rd_ptr_q];
    trace_instruction = mem_instr[rd_ptr_q];
    trace_data        = mem_data[rd_ptr_q];
    trace_rd          = mem_rd[rd_ptr_q];
    trace_cycle       = mem_cycle[rd_ptr_q];
    count             = count_q;
    overflow          = overflow_q;
    drop_count        = drop_count_q;
  end

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Directed bench for wb_retire_buffer (DEPTH=8).
module tb_wb_retire_buffer;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_RegWrite = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_instruction = '0;
  logic [31:0] wb_write_data = '0;
  logic [4:0]  wb_rd_addr = '0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_pc, trace_instruction, trace_data, trace_cycle;
  logic [4:0]  trace_rd;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_count;

  wb_retire_buffer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .wb_RegWrite       (wb_RegWrite),
    .wb_pc             (wb_pc),
    .wb_instruction    (wb_instruction),
    .wb_write_data     (wb_write_data),
    .wb_rd_addr        (wb_rd_addr),
    .trace_ready       (trace_ready),
    .trace_valid       (trace_valid),
    .trace_pc          (trace_pc),
    .trace_instruction (trace_instruction),
    .trace_data        (trace_data),
    .trace_rd          (trace_rd),
    .trace_cycle       (trace_cycle),
    .count             (count),
    .overflow          (overflow),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc = '0;   // expected cycle-counter value at the next edge

  logic [31:0] e_pc[$];
  logic [31:0] e_instr[$];
  logic [31:0] e_data[$];
  logic [4:0]  e_rd[$];
  logic [31:0] e_cyc[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) cyc++;
  endtask

  task automatic drive(input logic we, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] data, input logic [4:0] rd);
    wb_RegWrite    = we;
    wb_pc          = pc;
    wb_instruction = instr;
    wb_write_data  = data;
    wb_rd_addr     = rd;
  endtask

  // Commit one record on the next edge and remember what should come out.
  task automatic commit(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] data, input logic [4:0] rd);
    drive(1'b1, pc, instr, data, rd);
    e_pc.push_back(pc);
    e_instr.push_back(instr);
    e_data.push_back(data);
    e_rd.push_back(rd);
    e_cyc.push_back(cyc);
    tick();
    drive(1'b0, '0, '0, '0, '0);
  endtask

  task automatic check_head(input string tag);
    check({tag, "_valid"}, trace_valid, 1);
    check({tag, "_pc"}, trace_pc, e_pc[0]);
    check({tag, "_instr"}, trace_instruction, e_instr[0]);
    check({tag, "_data"}, trace_data, e_data[0]);
    check({tag, "_rd"}, trace_rd, e_rd[0]);
    check({tag, "_cycle"}, trace_cycle, e_cyc[0]);
  endtask

  task automatic pop_one();
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    void'(e_pc.pop_front());
    void'(e_instr.pop_front());
    void'(e_data.pop_front());
    void'(e_rd.pop_front());
    void'(e_cyc.pop_front());
  endtask

  // Asynchronous reset pulse, asserted between edges; state must clear at once.
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check({tag, "_count"}, count, 0);
    check({tag, "_valid"}, trace_valid, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_drops"}, drop_count, 0);
    drive(1'b0, '0, '0, '0, '0);
    trace_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = '0;
    e_pc.delete(); e_instr.delete(); e_data.delete(); e_rd.delete(); e_cyc.delete();
  endtask

  initial begin
    int seen;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("init_count", count, 0);
    check("init_valid", trace_valid, 0);
    check("init_ovf", overflow, 0);
    check("init_drops", drop_count, 0);
    reset = 1'b1;
    cyc = '0;

    // Single commit at cycle 3.
    repeat (3) tick();
    commit(32'h0, 32'h0050_0093, 32'd5, 5'd1);
    check("single_count", count, 1);
    check("single_stamp", trace_cycle, 3);
    check_head("single");
    pop_one();
    check("single_drained", trace_valid, 0);

    // Ready with nothing queued has no effect.
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    check("idle_ready_count", count, 0);

    // Fill to DEPTH, then one more commit is dropped.
    for (int i = 0; i < 8; i++)
      commit(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 32'(3 * i), 5'(i));
    check("full_count", count, 8);
    check("full_no_ovf", overflow, 0);
    drive(1'b1, 32'hDEAD, 32'hBEEF, 32'h1, 5'd9);
    tick();
    drive(1'b0, '0, '0, '0, '0);
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 1);
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("drain%0d", i));
      pop_one();
    end
    check("drain_count", count, 0);
    check("drain_valid", trace_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Empty with push and pop together: only the push happens.
    trace_ready = 1'b1;
    commit(32'h0, 32'h13, 32'h0, 5'd0);
    trace_ready = 1'b0;
    check("pushpop_empty_count", count, 1);
    check_head("rd0");
    pop_one();

    // Full with push and pop together: no drop, new entry becomes tail.
    reset_pulse("rst1");
    for (int i = 0; i < 8; i++)
      commit(32'h800 + 32'(4 * i), 32'h33, 32'(i), 5'd2);
    trace_ready = 1'b1;
    commit(32'h900, 32'h77, 32'h99, 5'd31);
    trace_ready = 1'b0;
    void'(e_pc.pop_front()); void'(e_instr.pop_front()); void'(e_data.pop_front());
    void'(e_rd.pop_front()); void'(e_cyc.pop_front());
    check("fullpp_count", count, 8);
    check("fullpp_ovf", overflow, 0);
    check("fullpp_drops", drop_count, 0);
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("fullpp%0d", i));
      pop_one();
    end
    check("fullpp_empty", count, 0);

    // Streaming with ready held high across pointer wrap.
    seen = 0;
    trace_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("stream_count%0d", i), count, 32'(e_pc.size()));
      check($sformatf("stream_le1_%0d", i), 32'(count <= 4'd1), 1);
      if (e_pc.size() > 0) begin
        check($sformatf("stream_pc%0d", i), trace_pc, e_pc[0]);
        check($sformatf("stream_cyc%0d", i), trace_cycle, e_cyc[0]);
        void'(e_pc.pop_front()); void'(e_instr.pop_front()); void'(e_data.pop_front());
        void'(e_rd.pop_front()); void'(e_cyc.pop_front());
        seen++;
      end
      commit(32'h2000 + 32'(4 * i), 32'h13, 32'(i), 5'd4);
    end
    check("stream_last_pc", trace_pc, e_pc[0]);
    pop_one();
    seen++;
    trace_ready = 1'b0;
    check("stream_seen", 32'(seen), 20);
    check("stream_drops", drop_count, 0);
    check("stream_empty", count, 0);

    // Async reset mid-cycle with five entries queued, commit still asserted.
    for (int i = 0; i < 5; i++)
      commit(32'h3000 + 32'(4 * i), 32'h13, 32'(i), 5'd5);
    check("five_count", count, 5);
    drive(1'b1, 32'h4444, 32'h13, 32'h1, 5'd6);
    reset_pulse("rst_mid");

    // First edge after release stamps cycle 0.
    commit(32'h5000, 32'h13, 32'h7, 5'd7);
    check("post_rst_stamp", trace_cycle, 0);
    check("post_rst_count", count, 1);
    pop_one();

    // Drop counter saturation.
    for (int i = 0; i < 8; i++)
      commit(32'h6000 + 32'(4 * i), 32'h13, 32'(i), 5'd8);
    drive(1'b1, 32'h7000, 32'h13, 32'h0, 5'd9);
    repeat (3) tick();
    check("drops3", drop_count, 3);
    repeat (70000 - 3) tick();
    drive(1'b0, '0, '0, '0, '0);
    check("drops_sat", drop_count, 16'hFFFF);
    check("drops_ovf", overflow, 1);
    check("drops_count", count, 8);
    check_head("drops_head");
    reset_pulse("rst_sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_retire_buffer.md
WB_RETIRE_BUFFER -- requirements
Module: wb_retire_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of trace entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 wb_RegWrite  input  1  WB-stage commit strobe; 1 = a retiring instruction is presented this cycle.
REQ-005 wb_pc  input  32  PC of the retiring instruction.
REQ-006 wb_instruction  input  32  encoding of the retiring instruction.
REQ-007 wb_write_data  input  32  value written to the register file.
REQ-008 wb_rd_addr  input  5  destination register index.
REQ-009 trace_ready  input  1  consumer accepts the head entry when 1 together with trace_valid.
REQ-010 trace_valid  output  1  1 = a trace entry is presented.
REQ-011 trace_pc, trace_instruction, trace_data  output  32 each  head-entry fields.
REQ-012 trace_rd  output  5  head-entry destination register.
REQ-013 trace_cycle  output  32  cycle stamp of the head entry.
REQ-014 count  output  $clog2(DEPTH)+1  number of entries held.
REQ-015 overflow  output  1  sticky; 1 = at least one commit was dropped.
REQ-016 drop_count  output  16  number of dropped commits, saturating.

Function
REQ-017 The block SHALL be a first-word-fall-through FIFO of {pc, instruction, write_data, rd_addr, cycle} records.
REQ-018 Free-running 32-bit cycle counter: 0 after reset, +1 every clk edge while reset is deasserted, wraps from 0xFFFFFFFF to 0.
REQ-019 Push: when wb_RegWrite=1 at a clock edge, the WB fields plus the current cycle-counter value (pre-increment) SHALL be written if space is available.
REQ-020 Pop: trace_valid=1 and trace_ready=1 at a clock edge removes the head entry.
REQ-021 trace_valid SHALL equal (count != 0); trace_* SHALL present the head entry with zero-cycle latency from the storage read (combinational read).
REQ-022 A push into an empty FIFO SHALL make trace_valid=1 on the cycle after the push edge.
REQ-023 Full (count=DEPTH) with push and pop at the same edge: both SHALL occur, count unchanged, no drop.
REQ-024 Full with push and no pop: the commit SHALL be discarded, overflow set to 1, drop_count +1, saturating at 0xFFFF.
REQ-025 Empty with push and pop at the same edge: the pop SHALL be ignored (trace_valid=0), the push SHALL occur, and count becomes 1.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; entries SHALL leave in arrival order across wrap.
REQ-027 trace_ready with trace_valid=0 SHALL have no effect.
REQ-028 wb_rd_addr=0 commits SHALL be recorded like any other; no filtering.
REQ-029 When trace_valid=0, the trace_* data outputs are don't-care.

Reset
REQ-030 Asserting reset at any time, including mid-push or mid-pop, SHALL immediately clear:
  - count=0, trace_valid=0
  - both pointers
  - cycle counter=0
  - overflow=0, drop_count=0
REQ-031 Storage contents SHALL NOT require reset.
REQ-032 The first edge after deassertion SHALL operate normally, using cycle stamp 0.

Verification
REQ-033 Reset release, then a single commit at cycle 3 with pc=0x0, instr=0x00500093, data=5, rd=1 -> next cycle trace_valid=1, trace_cycle=3, all fields as driven, count=1.
REQ-034 DEPTH=8; 8 back-to-back commits with trace_ready=0, then a 9th commit -> count=8, overflow=1, drop_count=1; drain returns the first 8 in order.
REQ-035 Full FIFO, commit and trace_ready=1 at the same edge -> count stays 8, overflow stays 0, the new entry becomes the tail.
REQ-036 Continuous commits with trace_ready=1 for 20 cycles (pointer wrap) -> every pc is observed once, in order, count is at most 1, no drops.
REQ-037 70000 drops while full -> drop_count saturates at 0xFFFF; reset pulse -> drop_count=0, overflow=0, trace_valid=0.
REQ-038 Reset asserted asynchronously between edges with count=5 -> count=0 and trace_valid=0 immediately, without waiting for a clock edge.
